// File: rtl/rf_wr_arbiter.sv
// Two-port register-file write arbiter: round-robin between ALU and load
// writeback, one registered write per cycle, with halt/drain control.
module rf_wr_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [3:0]       addr0,
    input  logic [15:0]      data0,
    output logic             gnt0,
    input  logic             req1,
    input  logic [3:0]       addr1,
    input  logic [15:0]      data1,
    output logic             gnt1,
    input  logic             hlt,
    input  logic [3:0]       rd_addr0,
    input  logic [3:0]       rd_addr1,
    output logic             hit0,
    output logic             hit1,
    output logic [3:0]       dst_addr,
    output logic [15:0]      dst,
    output logic             we,
    output logic             halted,
    output logic [CNT_W-1:0] wr_cnt
);

    typedef enum logic [1:0] {
        S_RUN,
        S_DRAIN,
        S_HALTED
    } state_t;

    state_t           state_q, state_d;
    logic             last_q, last_d;
    logic [3:0]       dst_addr_q, dst_addr_d;
    logic [15:0]      dst_q, dst_d;
    logic             we_q, we_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic             run_ok;

    // last_q=1 means port 1 was granted most recently, so port 0 wins ties
    always_comb begin
        run_ok = rst_n && (state_q == S_RUN) && !hlt;
        gnt0   = run_ok && req0 && (!req1 || last_q);
        gnt1   = run_ok && req1 && (!req0 || !last_q);

        last_d     = last_q;
        dst_addr_d = dst_addr_q;
        dst_d      = dst_q;
        we_d       = 1'b0;
        if (gnt0) begin
            last_d     = 1'b0;
            dst_addr_d = addr0;
            dst_d      = data0;
            we_d       = (addr0 != 4'd0);
        end else if (gnt1) begin
            last_d     = 1'b1;
            dst_addr_d = addr1;
            dst_d      = data1;
            we_d       = (addr1 != 4'd0);
        end

        wr_cnt_d = wr_cnt_q;
        if (we_q && !(&wr_cnt_q)) begin
            wr_cnt_d = wr_cnt_q + CNT_W'(1);
        end

        state_d = state_q;
        unique case (state_q)
            S_RUN: begin
                if (hlt) begin
                    state_d = we_q ? S_DRAIN : S_HALTED;
                end
            end
            S_DRAIN:  state_d = S_HALTED;
            S_HALTED: state_d = hlt ? S_HALTED : S_RUN;
            default:  state_d = S_RUN;
        endcase
        halted_d = (state_d == S_HALTED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_RUN;
            last_q     <= 1'b1;
            dst_addr_q <= 4'd0;
            dst_q      <= 16'd0;
            we_q       <= 1'b0;
            halted_q   <= 1'b0;
            wr_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            dst_addr_q <= dst_addr_d;
            dst_q      <= dst_d;
            we_q       <= we_d;
            halted_q   <= halted_d;
            wr_cnt_q   <= wr_cnt_d;
        end
    end

    assign hit0     = we_q && (rd_addr0 == dst_addr_q) && (rd_addr0 != 4'd0);
    assign hit1     = we_q && (rd_addr1 == dst_addr_q) && (rd_addr1 != 4'd0);
    assign dst_addr = dst_addr_q;
    assign dst      = dst_q;
    assign we       = we_q;
    assign halted   = halted_q;
    assign wr_cnt   = wr_cnt_q;

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Directed bench for rf_wr_arbiter: arbitration, latency, halt/drain,
// hazard hits, reset discard and counter saturation.
module tb_rf_wr_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0, req1, hlt;
    logic [3:0]  addr0, addr1, rd_addr0, rd_addr1;
    logic [15:0] data0, data1;
    logic        gnt0, gnt1, hit0, hit1, we, halted;
    logic [3:0]  dst_addr;
    logic [15:0] dst;
    logic [15:0] wr_cnt;

    logic        s_gnt0, s_gnt1, s_hit0, s_hit1, s_we, s_halted;
    logic [3:0]  s_dst_addr;
    logic [15:0] s_dst;
    logic [1:0]  s_wr_cnt;

    int checks = 0;
    int errors = 0;

    rf_wr_arbiter #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .addr0(addr0), .data0(data0), .gnt0(gnt0),
        .req1(req1), .addr1(addr1), .data1(data1), .gnt1(gnt1),
        .hlt(hlt), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
        .hit0(hit0), .hit1(hit1), .dst_addr(dst_addr), .dst(dst),
        .we(we), .halted(halted), .wr_cnt(wr_cnt)
    );

    rf_wr_arbiter #(.CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .addr0(addr0), .data0(data0), .gnt0(s_gnt0),
        .req1(req1), .addr1(addr1), .data1(data1), .gnt1(s_gnt1),
        .hlt(hlt), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
        .hit0(s_hit0), .hit1(s_hit1), .dst_addr(s_dst_addr), .dst(s_dst),
        .we(s_we), .halted(s_halted), .wr_cnt(s_wr_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; hlt = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        addr0 = 4'd0; addr1 = 4'd0; data0 = 16'h0; data1 = 16'h0;
        rd_addr0 = 4'd0; rd_addr1 = 4'd0;
        step(); step();
        chk("rst_gnt0", gnt0, 0);
        chk("rst_gnt1", gnt1, 0);
        chk("rst_we", we, 0);
        chk("rst_dst_addr", dst_addr, 0);
        chk("rst_dst", dst, 0);
        chk("rst_halted", halted, 0);
        chk("rst_wr_cnt", wr_cnt, 0);

        // both requesting after reset: port 0 first, then port 1
        rst_n = 1'b1;
        addr0 = 4'd3; data0 = 16'h1111;
        addr1 = 4'd5; data1 = 16'h2222;
        #1;
        chk("rr_c0_gnt0", gnt0, 1);
        chk("rr_c0_gnt1", gnt1, 0);
        step();
        chk("rr_c1_gnt0", gnt0, 0);
        chk("rr_c1_gnt1", gnt1, 1);
        chk("rr_c1_we", we, 1);
        chk("rr_c1_addr", dst_addr, 3);
        chk("rr_c1_dst", dst, 16'h1111);
        chk("rr_c1_cnt", wr_cnt, 0);
        step();
        req0 = 1'b0; req1 = 1'b0;
        #1;
        chk("rr_c2_we", we, 1);
        chk("rr_c2_addr", dst_addr, 5);
        chk("rr_c2_dst", dst, 16'h2222);
        chk("rr_c2_cnt", wr_cnt, 1);
        step();
        chk("rr_c3_we", we, 0);
        chk("rr_c3_addr_hold", dst_addr, 5);
        chk("rr_c3_cnt", wr_cnt, 2);

        // grant to register 0 produces no write
        req1 = 1'b1; addr1 = 4'd0; data1 = 16'hBEEF;
        #1;
        chk("r0_gnt1", gnt1, 1);
        chk("r0_gnt0", gnt0, 0);
        step();
        req1 = 1'b0;
        chk("r0_we", we, 0);
        chk("r0_addr", dst_addr, 0);
        chk("r0_dst", dst, 16'hBEEF);
        step();
        chk("r0_cnt", wr_cnt, 2);

        // read hazard hit against the issuing write
        req0 = 1'b1; addr0 = 4'd9; data0 = 16'h0909;
        #1;
        chk("hit_gnt0", gnt0, 1);
        step();
        req0 = 1'b0; rd_addr0 = 4'd9; rd_addr1 = 4'd0;
        #1;
        chk("hit_we", we, 1);
        chk("hit_hit0", hit0, 1);
        chk("hit_hit1", hit1, 0);
        step();
        chk("hit_idle_we", we, 0);
        chk("hit_idle_hit0", hit0, 0);
        chk("hit_cnt", wr_cnt, 3);
        rd_addr0 = 4'd0;

        // halt while a write issues: RUN -> DRAIN -> HALTED
        req0 = 1'b1; addr0 = 4'd7; data0 = 16'h7777;
        #1;
        chk("hlt_n_gnt0", gnt0, 1);
        step();
        hlt = 1'b1;
        #1;
        chk("hlt_n1_gnt0", gnt0, 0);
        chk("hlt_n1_we", we, 1);
        chk("hlt_n1_addr", dst_addr, 7);
        step();
        chk("hlt_n2_gnt0", gnt0, 0);
        chk("hlt_n2_we", we, 0);
        chk("hlt_n2_halted", halted, 0);
        chk("hlt_n2_cnt", wr_cnt, 4);
        step();
        chk("hlt_n3_halted", halted, 1);
        chk("hlt_n3_gnt0", gnt0, 0);
        hlt = 1'b0;
        #1;
        chk("hlt_exit_gnt0", gnt0, 0);
        step();
        chk("hlt_run_halted", halted, 0);
        chk("hlt_run_gnt0", gnt0, 1);
        req0 = 1'b0;
        #1;
        chk("withdraw_gnt0", gnt0, 0);
        step();
        chk("withdraw_we", we, 0);
        chk("withdraw_cnt", wr_cnt, 4);

        // halt dropped during DRAIN still passes through HALTED
        req0 = 1'b1; addr0 = 4'd2; data0 = 16'h0002;
        #1;
        chk("drn_gnt0", gnt0, 1);
        step();
        req0 = 1'b0; hlt = 1'b1;
        #1;
        chk("drn_we", we, 1);
        step();
        hlt = 1'b0;
        #1;
        chk("drn_halted0", halted, 0);
        step();
        chk("drn_halted1", halted, 1);
        step();
        chk("drn_run", halted, 0);
        chk("drn_cnt", wr_cnt, 5);

        // reset right after a grant discards the write
        req0 = 1'b1; addr0 = 4'd4; data0 = 16'h4444;
        #1;
        chk("rw_gnt0", gnt0, 1);
        step();
        req0 = 1'b0;
        #1;
        chk("rw_we_pre", we, 1);
        chk("rw_addr_pre", dst_addr, 4);
        rst_n = 1'b0;
        #1;
        chk("rw_we_rst", we, 0);
        chk("rw_cnt_rst", wr_cnt, 0);
        chk("rw_addr_rst", dst_addr, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("rw_we_after", we, 0);
        chk("rw_cnt_after", wr_cnt, 0);
        req0 = 1'b1; req1 = 1'b1; addr0 = 4'd1; addr1 = 4'd2;
        #1;
        chk("rw_prio_gnt0", gnt0, 1);
        chk("rw_prio_gnt1", gnt1, 0);
        req1 = 1'b0;

        // four back-to-back writes saturate a 2-bit counter
        for (int i = 0; i < 5; i++) begin
            req0  = (i < 4);
            addr0 = 4'(i + 1);
            data0 = 16'(i);
            step();
            chk($sformatf("sat_cnt_%0d", i), s_wr_cnt, (i > 3) ? 3 : i);
        end
        req0 = 1'b0;
        chk("sat_main_cnt", wr_cnt, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_wr_arbiter.md
RF_WR_ARBITER -- requirements
Module: rf_wr_arbiter

Interface
REQ-001 Parameter: CNT_W, default 16, width of the completed-write counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req0  input  1  requester 0 (ALU writeback) write request, held until gnt0.
REQ-005 addr0  input  4  requester 0 destination register.
REQ-006 data0  input  16  requester 0 write data.
REQ-007 gnt0  output  1  combinational accept of requester 0 this cycle.
REQ-008 req1, addr1, data1, gnt1: same as REQ-004..007 for requester 1 (load writeback).
REQ-009 hlt  input  1  halt request; stop accepting writes, drain, hold.
REQ-010 rd_addr0, rd_addr1  input  4 each  register-file read-port addresses for hazard check.
REQ-011 hit0, hit1  output  1 each  read address matches the write issuing this cycle.
REQ-012 dst_addr  output  4  register-file write address (registered).
REQ-013 dst  output  16  register-file write data (registered).
REQ-014 we  output  1  register-file write enable (registered).
REQ-015 halted  output  1  registered; high while in HALTED state.
REQ-016 wr_cnt  output  CNT_W  count of writes issued with we=1.

Function
REQ-017 States RUN, DRAIN, HALTED; reset state RUN.
REQ-018 RUN: at most one grant per cycle; gnt_i=1 only if req_i=1 and port i wins arbitration.
REQ-019 Arbitration round-robin: single request wins; both requesting, port not granted most recently wins; after reset port 0 has priority.
REQ-020 Last-granted pointer updates only on a cycle with a grant.
REQ-021 Latency 1: request granted in cycle N drives dst_addr/dst in cycle N+1; we=1 in N+1 only if granted addr != 0.
REQ-022 Grant with addr=0 is accepted (gnt pulses) but produces we=0 in N+1; dst_addr/dst still load the granted values.
REQ-023 Cycle with no grant: we=0 next cycle; dst_addr/dst hold previous values.
REQ-024 wr_cnt increments by 1 on each cycle where we=1; saturates at all-ones.
REQ-025 RUN with hlt=1: no grants that cycle; next state DRAIN if we=1 this cycle, else HALTED.
REQ-026 DRAIN: no grants; next state HALTED (issued write retires this cycle).
REQ-027 HALTED: no grants, we=0, halted=1; hlt=0 returns to RUN next cycle.
REQ-028 DRAIN with hlt=0: still proceeds to HALTED, then RUN next cycle if hlt still 0.
REQ-029 hit_i = we && (rd_addr_i == dst_addr) && (rd_addr_i != 0), combinational.
REQ-030 req_i deasserted without gnt: request withdrawn, no write, pointer unchanged.

Reset
REQ-031 rst_n=0 asynchronously forces: state RUN, pointer favors port 0, dst_addr=0, dst=0, we=0, halted=0, wr_cnt=0.
REQ-032 While rst_n=0, gnt0=gnt1=0 and hit0=hit1=0.
REQ-033 Reset mid-write discards the pending write; no we pulse after rst_n release until a new grant.
REQ-034 First grant possible in first rising edge after rst_n deasserts.

Verification
REQ-035 After reset, req0=req1=1, addr0=3/data0=1111, addr1=5/data1=2222 held -> gnt0 cycle 0, gnt1 cycle 1; we with R3=1111 cycle 1, R5=2222 cycle 2; wr_cnt=2.
REQ-036 req1 alone, addr1=0, data1=BEEF -> gnt1=1, next cycle we=0, dst_addr=0, wr_cnt unchanged.
REQ-037 Grant addr0=7 in cycle N, hlt=1 in N+1 -> state DRAIN, we=1 in N+1, halted=1 in N+3; req0 during hlt -> gnt0=0.
REQ-038 Write to R9 issuing, rd_addr0=9, rd_addr1=0 -> hit0=1, hit1=0; rd_addr0=9 with we=0 -> hit0=0.
REQ-039 rst_n pulsed low in cycle after grant of R4 -> we=0 immediately, no write to R4, wr_cnt=0.
REQ-040 CNT_W=2, four consecutive nonzero writes -> wr_cnt 1,2,3,3 (saturated).
